// File: rtl/program_loader.sv
// program_loader: sequences loading of the MC14500B text RAM from a byte stream
// and decides when the core may run.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   -> an 8-bit XOR over the length byte and every word byte is
//                checked against one trailing byte after the last word
//   undefined -> the last word write goes straight to DONE
//
// Ports:
//   i_clk            system clock, rising edge
//   i_reset          asynchronous, active-high reset
//   i_start          level request for a new load (honoured in IDLE/DONE/ERROR)
//   i_rx_data        incoming byte
//   i_rx_valid       i_rx_data valid
//   o_rx_ready       loader accepts a byte this cycle
//   o_program_write  one-cycle text RAM write strobe
//   o_program_addr   text RAM write address
//   o_program_cmd    program word to write
//   o_cpu_hold       1 = core held in reset
//   o_busy           load in progress
//   o_done           last load completed successfully (sticky)
//   o_error          last load aborted (sticky)
module program_loader #(
    parameter int ADDR_WIDTH        = 8,
    parameter int INSTRUCTION_WIDTH = 4,
    parameter int DATA_WIDTH        = ADDR_WIDTH + INSTRUCTION_WIDTH,
    parameter int TIMEOUT_CYCLES    = 1000000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    output logic                  o_program_write,
    output logic [ADDR_WIDTH-1:0] o_program_addr,
    output logic [DATA_WIDTH-1:0] o_program_cmd,
    output logic                  o_cpu_hold,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);
    localparam int MAX_IDX = (1 << ADDR_WIDTH) - 1;
    localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_HI, S_LO, S_WR, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [ADDR_WIDTH-1:0] r_last;
    logic [DATA_WIDTH-1:0] r_word;
    logic [TW-1:0]         r_tmo;
    logic                  w_accept;
    logic                  w_start;
    logic                  w_tmo;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            r_csum;
`endif

    assign w_accept = i_rx_valid & o_rx_ready;
    assign w_start  = i_start & (r_state inside {S_IDLE, S_DONE, S_ERR});
    // Timeout fires on the TIMEOUT_CYCLES-th consecutive waiting cycle without a byte.
    assign w_tmo    = o_rx_ready & ~w_accept & (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: w_next = i_start ? S_LEN : r_state;
            S_LEN:                 w_next = w_accept ? S_HI : S_LEN;
            S_HI:                  w_next = w_accept ? S_LO : S_HI;
            S_LO:                  w_next = w_accept ? S_WR : S_LO;
`ifdef LOADER_CHECKSUM_EN
            S_WR:                  w_next = (r_index == r_last) ? S_CHK : S_HI;
            S_CHK:                 w_next = w_accept ? ((i_rx_data == r_csum) ? S_DONE : S_ERR) : S_CHK;
`else
            S_WR:                  w_next = (r_index == r_last) ? S_DONE : S_HI;
`endif
            default:               w_next = S_IDLE;
        endcase
        if (w_tmo)
            w_next = S_ERR;
    end

    // cpu_hold is a decode of the state register, so it rises one cycle after
    // start is sampled and drops in the first DONE cycle.
    always_comb begin
        o_rx_ready      = r_state inside {S_LEN, S_HI, S_LO, S_CHK};
        o_program_write = r_state == S_WR;
        o_busy          = r_state inside {S_LEN, S_HI, S_LO, S_WR, S_CHK};
        o_done          = r_state == S_DONE;
        o_error         = r_state == S_ERR;
        o_cpu_hold      = o_busy | o_error;
        o_program_addr  = r_index;
        o_program_cmd   = r_word;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_index <= '0;
            r_last  <= '0;
            r_word  <= '0;
            r_tmo   <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum  <= '0;
`endif
        end else if (w_start) begin
            r_index <= '0;
            r_tmo   <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum  <= '0;
`endif
        end else begin
            r_tmo <= (w_accept | ~o_rx_ready) ? '0 : r_tmo + TW'(1);
`ifdef LOADER_CHECKSUM_EN
            if (w_accept)
                r_csum <= r_csum ^ i_rx_data;
`endif
            // Word count N+1 is clipped to the RAM size by clipping the last index.
            if (w_accept && r_state == S_LEN)
                r_last <= ADDR_WIDTH'((int'(i_rx_data) > MAX_IDX) ? MAX_IDX : int'(i_rx_data));
            // Assembling via a 16-bit value keeps only the low DATA_WIDTH bits.
            if (w_accept && r_state == S_HI)
                r_word <= DATA_WIDTH'({i_rx_data, 8'h00});
            if (w_accept && r_state == S_LO)
                r_word <= r_word | DATA_WIDTH'(i_rx_data);
            if (r_state == S_WR && r_index != r_last)
                r_index <= r_index + ADDR_WIDTH'(1);
        end
    end
endmodule
